// File: rtl/alu_seq.sv
// alu_seq: sequential unsigned ALU (MAX, MIN, MOD, DIV).
// MAX/MIN and error cases finish in one cycle. MOD/DIV use a restoring divider
// that retires one quotient bit per cycle for WIDTH cycles. Operands are
// captured when a request is accepted. valid_o, busy_o, res_o and err_o are
// all registered.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       alu_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] MODE_MAX = 3'd0;
  localparam logic [2:0] MODE_MIN = 3'd1;
  localparam logic [2:0] MODE_MOD = 3'd2;
  localparam logic [2:0] MODE_DIV = 3'd3;

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q;    // operand A; holds the quotient bits while dividing
  logic [WIDTH-1:0] b_q;
  logic [2:0]       mode_q;
  logic [WIDTH:0]   rem_q;  // partial remainder, one guard bit wide
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             valid_q;
  logic             busy_q;
  logic             err_q;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   rem_step_s;
  logic             qbit_s;
  logic             divides_s;
  logic [WIDTH-1:0] res_d;
  logic             err_d;

  // Accepting a MOD/DIV with a non-zero divisor starts the divider.
  assign divides_s = ((alu_mode_i == MODE_MOD) || (alu_mode_i == MODE_DIV)) &&
                     (op_b_i != {WIDTH{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (divides_s) begin
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring-division step. The shifted remainder is below 2*B, so the
  // difference fits in WIDTH+1 bits and its top bit is a valid borrow.
  always_comb begin
    shifted_s = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, b_q};
    qbit_s    = ~diff_s[WIDTH];
    if (qbit_s) begin
      rem_step_s = diff_s;
    end else begin
      rem_step_s = shifted_s;
    end
  end

  // Final result and error flag, selected from the latched operation.
  always_comb begin
    res_d = {WIDTH{1'b0}};
    err_d = 1'b0;
    case (mode_q)
      MODE_MAX: begin
        if (a_q > b_q) begin
          res_d = a_q;
        end else begin
          res_d = b_q;
        end
      end
      MODE_MIN: begin
        if (a_q < b_q) begin
          res_d = a_q;
        end else begin
          res_d = b_q;
        end
      end
      MODE_MOD: begin
        if (b_q == {WIDTH{1'b0}}) begin
          res_d = a_q;
          err_d = 1'b1;
        end else begin
          res_d = rem_q[WIDTH-1:0];
        end
      end
      MODE_DIV: begin
        if (b_q == {WIDTH{1'b0}}) begin
          res_d = {WIDTH{1'b1}};
          err_d = 1'b1;
        end else begin
          res_d = a_q;
        end
      end
      default: begin
        res_d = {WIDTH{1'b0}};
        err_d = 1'b1;
      end
    endcase
  end

  // Operand capture, divider datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      mode_q  <= 3'd0;
      rem_q   <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q    <= op_a_i;
            b_q    <= op_b_i;
            mode_q <= alu_mode_i;
            rem_q  <= {(WIDTH+1){1'b0}};
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= {a_q[WIDTH-2:0], qbit_s};
          rem_q <= rem_step_s;
          cnt_q <= cnt_q + CNT_ONE;
        end
        DONE: begin
          res_q   <= res_d;
          err_q   <= err_d;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_o   = res_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq (WIDTH=16).
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] res;
  logic        valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_i      (rst),
    .start_i    (start),
    .alu_mode_i (mode),
    .op_a_i     (op_a),
    .op_b_i     (op_b),
    .res_o      (res),
    .valid_o    (valid),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, scramble inputs after the accept edge, wait for valid.
  task automatic do_op(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int busy_cnt);
    @(negedge clk);
    start = 1'b1; mode = m; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; op_a = ~a; op_b = b ^ 16'h5A5A;
    lat = 0;
    busy_cnt = (busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (valid === 1'b1) break;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    int pulses;
    logic [15:0] last_res;
    logic [3:0]  vpat;

    vecs[0]  = '{3'd0, 16'h8000, 16'h7FFF, 16'h8000, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b0, 1};
    vecs[2]  = '{3'd0, 16'h1234, 16'h1234, 16'h1234, 1'b0, 1};
    vecs[3]  = '{3'd1, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1};
    vecs[4]  = '{3'd2, 16'd100,  16'd7,    16'd2,    1'b0, 17};
    vecs[5]  = '{3'd3, 16'd100,  16'd7,    16'd14,   1'b0, 17};
    vecs[6]  = '{3'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17};
    vecs[7]  = '{3'd2, 16'd5,    16'd9,    16'd5,    1'b0, 17};
    vecs[8]  = '{3'd3, 16'd0,    16'd3,    16'd0,    1'b0, 17};
    vecs[9]  = '{3'd3, 16'd5,    16'd0,    16'hFFFF, 1'b1, 1};
    vecs[10] = '{3'd2, 16'd5,    16'd0,    16'd5,    1'b1, 1};
    vecs[11] = '{3'd6, 16'd5,    16'd3,    16'd0,    1'b1, 1};
    vecs[12] = '{3'd3, 16'hFFFF, 16'hFFFF, 16'd1,    1'b0, 17};
    vecs[13] = '{3'd2, 16'hFFFF, 16'h8000, 16'h7FFF, 1'b0, 17};
    vecs[14] = '{3'd3, 16'd1000, 16'd33,   16'd30,   1'b0, 17};
    vecs[15] = '{3'd2, 16'd1000, 16'd33,   16'd10,   1'b0, 17};

    rst = 1'b1; start = 1'b0; mode = 3'd0; op_a = 16'd0; op_b = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset res", {16'd0, res}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].m, vecs[i].a, vecs[i].b, lat, bc);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d res", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
      chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d busy at valid", i), {31'd0, busy}, 32'd0);
      chk($sformatf("vec%0d busy cycles", i), bc, vecs[i].exp_lat);
      @(posedge clk); #1;
      chk($sformatf("vec%0d pulse width", i), {31'd0, valid}, 32'd0);
      chk($sformatf("vec%0d res hold", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
    end

    // DIV 100/7 with an ignored MAX request arriving mid-operation.
    @(negedge clk);
    start = 1'b1; mode = 3'd3; op_a = 16'd100; op_b = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; lat = 0; last_res = 16'd0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 5) begin
        start = 1'b1; mode = 3'd0; op_a = 16'd1; op_b = 16'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        pulses++;
        lat = k;
        last_res = res;
      end
    end
    chk("ignored start pulses", pulses, 1);
    chk("ignored start latency", lat, 17);
    chk("ignored start res", {16'd0, last_res}, 32'd14);

    // Reset aborts a MOD in RUN; then a MIN completes normally.
    @(negedge clk);
    start = 1'b1; mode = 3'd2; op_a = 16'd100; op_b = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort res", {16'd0, res}, 32'd0);
    chk("abort valid", {31'd0, valid}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) pulses++;
    end
    chk("abort no valid", pulses, 0);
    do_op(3'd1, 16'd3, 16'd4, lat, bc);
    chk("post-abort MIN latency", lat, 1);
    chk("post-abort MIN res", {16'd0, res}, 32'd3);
    chk("post-abort MIN err", {31'd0, err}, 32'd0);

    // Back-to-back MAX with start held high: accepted every second edge.
    @(negedge clk);
    start = 1'b1; mode = 3'd0; op_a = 16'd5; op_b = 16'd9;
    vpat = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vpat[k] = valid;
    end
    @(negedge clk);
    start = 1'b0;
    chk("back-to-back valid pattern", {28'd0, vpat}, 32'hA);
    chk("back-to-back res", {16'd0, res}, 32'd9);
    @(posedge clk); #1;
    chk("back-to-back idle after", {30'd0, busy, valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
